// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared FFT definitions: default sizes, the twiddle pair type, and the
// quadrant fold that maps a full-circle index onto the quarter-wave cosine
// table. The DIF/DIT address generators use the same fold.
// ---------------------------------------------------------------------------
package fft_pkg;

    localparam int LOG2N_DEF = 8;   // log2 of the maximum FFT size
    localparam int TW_W_DEF  = 15;  // twiddle width, Q(TW_W-2)

    typedef struct packed {
        logic signed [TW_W_DEF-1:0] re;
        logic signed [TW_W_DEF-1:0] im;
    } tw_t;

    // How one quadrant is rebuilt from the two table reads C[j] and C[M-j].
    typedef struct packed {
        logic swap;     // real part comes from C[M-j], sine from C[j]
        logic neg_re;   // negate the real part
        logic neg_sin;  // negate the sine
    } fold_t;

    //   q0: re =  C[j],   sin =  C[M-j]
    //   q1: re = -C[M-j], sin =  C[j]
    //   q2: re = -C[j],   sin = -C[M-j]
    //   q3: re =  C[M-j], sin = -C[j]
    function automatic fold_t quadrant_fold(input logic [1:0] q);
        fold_t f;
        f.swap    = q[0];
        f.neg_re  = q[0] ^ q[1];
        f.neg_sin = q[1];
        return f;
    endfunction

endpackage

// File: rtl/tw_qcos_rom.sv
// ---------------------------------------------------------------------------
// tw_qcos_rom
// Quarter-wave cosine table, N/4+1 words of round(cos(2*pi*i/N) * 2^(TW_W-2)),
// i = 0..N/4, with two synchronous read ports sharing one read enable.
// The contents are built at elaboration by a fixed-point series evaluation,
// so no image file or initialisation block is needed.
// Ports:
//   clk            clock
//   en             read enable; both read registers hold when low
//   addr_a/addr_b  read addresses, 0..N/4
//   data_a/data_b  registered words for the addresses presented last enable
// ---------------------------------------------------------------------------
module tw_qcos_rom #(
    parameter int LOG2N = 8,
    parameter int TW_W  = 15
) (
    input  logic             clk,
    input  logic             en,
    input  logic [LOG2N-2:0] addr_a,
    input  logic [LOG2N-2:0] addr_b,
    output logic [TW_W-1:0]  data_a,
    output logic [TW_W-1:0]  data_b
);

    localparam int     M      = 1 << (LOG2N - 2);
    localparam longint PI_Q30 = 64'sd3373259426;    // pi in Q30

    // cos(pi*idx/(N/2)) in Q30 by Taylor series, then rounded to Q(TW_W-2).
    // Q30 leaves ample guard bits, so the rounding matches real arithmetic.
    function automatic logic [TW_W-1:0] qcos_val(input int idx);
        longint x;
        longint x2;
        longint term;
        longint acc;
        longint scaled;
        x    = (PI_Q30 * longint'(idx)) >>> (LOG2N - 1);
        x2   = (x * x) >>> 30;
        term = 64'sd1 <<< 30;
        acc  = term;
        for (int n = 1; n <= 12; n++) begin
            term = -(((term * x2) >>> 30) / longint'((2 * n - 1) * (2 * n)));
            acc  = acc + term;
        end
        scaled = ((acc <<< (TW_W - 2)) + (64'sd1 <<< 29)) >>> 30;
        return scaled[TW_W-1:0];
    endfunction

    logic [TW_W-1:0] rom [0:M];

    for (genvar i = 0; i <= M; i++) begin : g_word
        localparam logic [TW_W-1:0] WORD = qcos_val(i);
        assign rom[i] = WORD;
    end

    // NOTE: read registers carry no reset; the valid pipeline alongside
    // decides whether their contents mean anything.
    always_ff @(posedge clk) begin
        if (en) begin
            data_a <= rom[addr_a];
            data_b <= rom[addr_b];
        end
    end

endmodule

// File: rtl/twiddle_gen.sv
// ---------------------------------------------------------------------------
// twiddle_gen
// Full-circle FFT/IFFT twiddle generator, W = exp(-/+ j*2*pi*k/N), from a
// quarter-wave cosine table using index mirroring and sign folding.
// Two-stage pipeline with one global enable; 2-cycle latency, 1 per clock.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (req_ready = ~tw_valid | tw_ready)
//   req_k                 index in the runtime-size domain
//   req_inv               0 = forward (imag = -sin), 1 = inverse (imag = +sin)
//   fft_log2n             runtime log2 size, clamped to 2..LOG2N
//   tw_valid/tw_ready     twiddle handshake
//   tw_real, tw_imag      cos(theta), -/+ sin(theta), signed Q(TW_W-2)
// ---------------------------------------------------------------------------
module twiddle_gen
    import fft_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEF,
    parameter int TW_W  = TW_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [LOG2N-1:0] req_k,
    input  logic             req_inv,
    input  logic [3:0]       fft_log2n,
    output logic             tw_valid,
    input  logic             tw_ready,
    output logic [TW_W-1:0]  tw_real,
    output logic [TW_W-1:0]  tw_imag
);

    localparam int M = 1 << (LOG2N - 2);

    // Whole pipe advances together; a bubble never blocks it.
    logic en;
    assign en        = ~tw_valid | tw_ready;
    assign req_ready = en;

    // ---- size scaling: K = (k mod 2^s) << (LOG2N - s) ---------------------
    logic [3:0]       size_s;
    logic [LOG2N-1:0] k_mask;
    logic [LOG2N-1:0] k_scaled;

    // NOTE: every output of a combinational block is assigned on all paths,
    // so no latch can be inferred.
    always_comb begin
        if (fft_log2n < 4'd2)
            size_s = 4'd2;
        else if (fft_log2n > 4'(LOG2N))
            size_s = 4'(LOG2N);
        else
            size_s = fft_log2n;
        // Shifting by LOG2N empties the shifted ones, so the mask becomes all ones.
        k_mask   = ~({LOG2N{1'b1}} << size_s);
        k_scaled = (req_k & k_mask) << (4'(LOG2N) - size_s);
    end

    logic [1:0]       quad;
    logic [LOG2N-3:0] j_idx;
    logic [LOG2N-2:0] addr_cos;
    logic [LOG2N-2:0] addr_sin;

    assign quad     = k_scaled[LOG2N-1:LOG2N-2];
    assign j_idx    = k_scaled[LOG2N-3:0];
    assign addr_cos = {1'b0, j_idx};
    assign addr_sin = (LOG2N - 1)'(M) - {1'b0, j_idx};

    // ---- stage 1: table reads, with quadrant and direction alongside -----
    logic [TW_W-1:0] cos_j;
    logic [TW_W-1:0] cos_mj;
    logic            s1_valid;
    logic [1:0]      s1_quad;
    logic            s1_inv;

    tw_qcos_rom #(
        .LOG2N (LOG2N),
        .TW_W  (TW_W)
    ) u_rom (
        .clk    (clk),
        .en     (en),
        .addr_a (addr_cos),
        .addr_b (addr_sin),
        .data_a (cos_j),
        .data_b (cos_mj)
    );

    // NOTE: registers use non-blocking assignments so every flop samples
    // the values from before the edge, whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (en) begin
            s1_valid <= req_valid;
            s1_quad  <= quad;
            s1_inv   <= req_inv;
        end
    end

    // ---- stage 2: quadrant swap and signs --------------------------------
    fold_t           fold;
    logic [TW_W-1:0] re_mag;
    logic [TW_W-1:0] sin_mag;
    logic [TW_W-1:0] re_next;
    logic [TW_W-1:0] im_next;

    always_comb begin
        fold    = quadrant_fold(s1_quad);
        re_mag  = fold.swap ? cos_mj : cos_j;
        sin_mag = fold.swap ? cos_j  : cos_mj;
        re_next = fold.neg_re ? -re_mag : re_mag;
        // imag = inv ? sin : -sin, so the forward direction flips the sine sign once more.
        im_next = (fold.neg_sin ^ ~s1_inv) ? -sin_mag : sin_mag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tw_valid <= 1'b0;
            tw_real  <= '0;
            tw_imag  <= '0;
        end else if (en) begin
            tw_valid <= s1_valid;
            tw_real  <= re_next;
            tw_imag  <= im_next;
        end
    end

endmodule

// File: tb/tb_twiddle_gen.sv
// ---------------------------------------------------------------------------
// tb_twiddle_gen
// Self-checking bench for twiddle_gen (N = 256, TW_W = 15). Expected twiddles
// come from real-valued cos/sin of the full angle, rounded half away from zero.
// ---------------------------------------------------------------------------
module tb_twiddle_gen;

    localparam int  LOG2N = 8;
    localparam int  TW_W  = 15;
    localparam int  N     = 1 << LOG2N;
    localparam real PI    = 3.14159265358979323846;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [LOG2N-1:0] req_k;
    logic             req_inv;
    logic [3:0]       fft_log2n;
    logic             tw_valid;
    logic             tw_ready;
    logic [TW_W-1:0]  tw_real;
    logic [TW_W-1:0]  tw_imag;

    always #5 clk = ~clk;

    twiddle_gen #(
        .LOG2N (LOG2N),
        .TW_W  (TW_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_k     (req_k),
        .req_inv   (req_inv),
        .fft_log2n (fft_log2n),
        .tw_valid  (tw_valid),
        .tw_ready  (tw_ready),
        .tw_real   (tw_real),
        .tw_imag   (tw_imag)
    );

    typedef struct packed {
        logic [TW_W-1:0] re;
        logic [TW_W-1:0] im;
    } exp_t;

    exp_t            exp_q[$];
    exp_t            pending;
    int              n_cmp = 0;
    int              n_fail = 0;
    int              cyc = 0;
    bit              track = 1'b0;
    int              first_acc;
    int              first_val;
    int              last_val;
    int              n_out;
    logic            stall_prev = 1'b0;
    logic            rst_prev = 1'b0;
    logic [TW_W-1:0] held_re;
    logic [TW_W-1:0] held_im;

    function automatic int rnd_away(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    // Twiddle from the full angle of the scaled index.
    function automatic exp_t model(input int k, input bit inv, input int l2n);
        int   s;
        int   kk;
        int   re_i;
        int   sn_i;
        int   im_i;
        real  th;
        real  sc;
        exp_t e;
        s    = (l2n < 2) ? 2 : ((l2n > LOG2N) ? LOG2N : l2n);
        kk   = (k % (1 << s)) * (1 << (LOG2N - s));
        th   = 2.0 * PI * real'(kk) / real'(N);
        sc   = real'(1 << (TW_W - 2));
        re_i = rnd_away($cos(th) * sc);
        sn_i = rnd_away($sin(th) * sc);
        im_i = inv ? sn_i : -sn_i;
        e.re = re_i[TW_W-1:0];
        e.im = im_i[TW_W-1:0];
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input int k, input bit inv, input int l2n, input bit rdy);
        req_valid = v;
        req_k     = k[LOG2N-1:0];
        req_inv   = inv;
        fft_log2n = l2n[3:0];
        tw_ready  = rdy;
        pending   = model(k, inv, l2n);
    endtask

    task automatic drive_lit(input int k, input bit inv, input int l2n,
                             input logic [TW_W-1:0] re, input logic [TW_W-1:0] im);
        drive(1'b1, k, inv, l2n, 1'b1);
        pending.re = re;
        pending.im = im;
    endtask

    // One clock: check req_ready and book the handshakes for the coming edge,
    // then check what the outputs show after it.
    task automatic step();
        bit consume;
        bit accept;
        #1;
        check("req_ready", {31'b0, req_ready}, {31'b0, ~tw_valid | tw_ready});
        consume    = tw_valid & tw_ready & ~rst;
        accept     = req_valid & req_ready & ~rst;
        stall_prev = tw_valid & ~tw_ready & ~rst;
        held_re    = tw_real;
        held_im    = tw_imag;
        rst_prev   = rst;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (consume && exp_q.size() != 0) void'(exp_q.pop_front());
            if (accept) begin
                exp_q.push_back(pending);
                if (track && first_acc < 0) first_acc = cyc;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst_prev) begin
            check("rst_valid", {31'b0, tw_valid}, 32'd0);
            check("rst_real", {17'b0, tw_real}, 32'd0);
            check("rst_imag", {17'b0, tw_imag}, 32'd0);
        end else begin
            if (stall_prev) begin
                check("stall_valid", {31'b0, tw_valid}, 32'd1);
                check("stall_real", {17'b0, tw_real}, {17'b0, held_re});
                check("stall_imag", {17'b0, tw_imag}, {17'b0, held_im});
            end
            if (tw_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", {31'b0, tw_valid}, 32'd0);
                end else begin
                    check("tw_real", {17'b0, tw_real}, {17'b0, exp_q[0].re});
                    check("tw_imag", {17'b0, tw_imag}, {17'b0, exp_q[0].im});
                end
                if (track && !stall_prev) begin
                    if (first_val < 0) first_val = cyc;
                    last_val = cyc;
                    n_out++;
                end
            end
        end
    endtask

    task automatic drain(input int max_cyc);
        for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) begin
            drive(1'b0, 0, 1'b0, LOG2N, 1'b1);
            step();
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 0, 1'b0, LOG2N, 1'b0);
        @(posedge clk);
        #1;
        step();                                   // reset state checked after this edge
        rst = 1'b0;

        // Cardinal and octant angles, forward.
        drive_lit(0,   1'b0, 8, 15'h2000, 15'h0000); step();
        drive(1'b1, 32, 1'b0, 8, 1'b1);              step();
        drive_lit(64,  1'b0, 8, 15'h0000, 15'h6000); step();
        drive_lit(128, 1'b0, 8, 15'h6000, 15'h0000); step();
        drive_lit(192, 1'b0, 8, 15'h0000, 15'h2000); step();
        // Inverse, small index, runtime size scaling and clamping.
        drive(1'b1, 32,  1'b1, 8,  1'b1); step();
        drive(1'b1, 1,   1'b1, 8,  1'b1); step();
        drive(1'b1, 1,   1'b1, 4,  1'b1); step();
        drive(1'b1, 16,  1'b1, 8,  1'b1); step();
        drive_lit(1,     1'b0, 0, 15'h0000, 15'h6000); step();
        drive(1'b1, 3,   1'b1, 0,  1'b1); step();
        drive(1'b1, 200, 1'b0, 15, 1'b1); step();
        drive(1'b1, 77,  1'b1, 5,  1'b1); step();
        drain(10);

        // Back-to-back sweep at full rate.
        track     = 1'b1;
        first_acc = -1;
        first_val = -1;
        last_val  = -1;
        n_out     = 0;
        for (int k = 0; k < N; k++) begin
            drive(1'b1, k, 1'b0, LOG2N, 1'b1);
            step();
        end
        drain(10);
        track = 1'b0;
        check("sweep_latency", 32'(first_val - first_acc), 32'd2);
        check("sweep_span", 32'(last_val - first_val + 1), 32'(N));
        check("sweep_count", 32'(n_out), 32'(N));

        // Random traffic with ~30% consumer stalls.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) < 8, int'($urandom_range(0, N - 1)),
                  bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                  $urandom_range(0, 9) >= 3);
            step();
        end
        drain(10);

        // Reset with two requests in the pipe: neither may ever be consumed.
        drive(1'b1, 40, 1'b0, 8, 1'b0); step();
        drive(1'b1, 90, 1'b1, 8, 1'b0); step();
        rst = 1'b1;
        drive(1'b0, 0, 1'b0, 8, 1'b0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 0, 1'b0, 8, 1'b1);
            step();
            check("post_rst_idle", {31'b0, tw_valid}, 32'd0);
        end
        drive(1'b1, 224, 1'b1, 8, 1'b1); step();
        drain(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
